// File: rtl/mem_pkg.sv
// Shared definitions for the load/store front-end: size codes, FSM states, alignment rule.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package mem_pkg;

   // Request size codes. Any size with bit 1 set is a byte access, so byte
   // decoding tests size[1] only; SIZE_BYTE is the canonical value.
   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LD,
      ST_MERGE,
      ST_WR,
      ST_RESP
   } state_t;

   // Halfwords must be 2-byte aligned and words 4-byte aligned; bytes never fault.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      if (size[1])
         bad = 1'b0;
      else if (size == SIZE_HALF)
         bad = addr_lo[0];
      else
         bad = (addr_lo != 2'b00);
      return bad;
   endfunction

endpackage

// File: rtl/sub_word_lane.sv
// Byte/halfword lane logic: extract+extend for loads, lane replace for stores.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: size/addr_lo/is_unsigned select the lane and extension; word_in is the
//        memory word; st_data supplies the store lane (low bits); ld_data is the
//        extended load value; st_merged is word_in with the addressed lane replaced.
module sub_word_lane
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        is_unsigned,
   input  logic [31:0] word_in,
   input  logic [31:0] st_data,
   output logic [31:0] ld_data,
   output logic [31:0] st_merged
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = word_in[{addr_lo, 3'b000} +: 8];
      half_lane = word_in[{addr_lo[1], 4'b0000} +: 16];
      ld_data   = word_in;
      st_merged = word_in;
      if (size[1]) begin
         ld_data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
         st_merged[{addr_lo, 3'b000} +: 8] = st_data[7:0];
      end else if (size == SIZE_HALF) begin
         ld_data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
         st_merged[{addr_lo[1], 4'b0000} +: 16] = st_data[15:0];
      end else begin
         // Word: loads pass through unextended, stores replace the whole word.
         ld_data   = word_in;
         st_merged = st_data;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-only sync-read memory; sub-word stores via read-modify-write.
// Latency: load 2, word store 2, sub-word store 3, misaligned 1 cycle(s) from accept to resp_valid.
// Backpressure: req_ready high only in IDLE; one request in flight, no back-to-back accepts.
// Ports: req_* request (fields latched on accept), resp_* one-cycle completion pulse with
//        held rdata/err, mem_* drive the memory (mem_rdata valid one cycle after mem_addr).
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_w_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [31:0]       wdata_q, wdata_d;   // store data at accept, merged word after MERGE
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [31:0]       lane_ld, lane_st;
   logic              accept;

   assign req_ready = (state_q == ST_IDLE);
   assign accept    = req_valid && req_ready;

   // In IDLE the request address goes straight to memory so the read data is
   // already valid in the LD/MERGE cycle; a read for an unaccepted request is harmless.
   assign mem_addr   = req_ready ? req_addr : addr_q;
   assign mem_w_en   = (state_q == ST_WR);
   assign mem_wdata  = wdata_q;
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   sub_word_lane u_lane (
      .size        (size_q),
      .addr_lo     (addr_q[1:0]),
      .is_unsigned (uns_q),
      .word_in     (mem_rdata),
      .st_data     (wdata_q),
      .ld_data     (lane_ld),
      .st_merged   (lane_st)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      size_d  = size_q;
      uns_d   = uns_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               addr_d  = req_addr;
               size_d  = req_size;
               uns_d   = req_unsigned;
               wdata_d = req_wdata;
               if (is_misaligned(req_size, req_addr[1:0])) begin
                  // Response fields only change on the edge into RESP.
                  rdata_d = 32'd0;
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else if (!req_we) begin
                  state_d = ST_LD;
               end else if (req_size == SIZE_WORD) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_MERGE;
               end
            end
         end
         ST_LD: begin
            rdata_d = lane_ld;
            err_d   = 1'b0;
            state_d = ST_RESP;
         end
         ST_MERGE: begin
            wdata_d = lane_st;
            state_d = ST_WR;
         end
         ST_WR: begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
            state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         size_q  <= SIZE_WORD;
         uns_q   <= 1'b0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit with a word memory model and a behavioural reference.
module tb_mem_access_unit;
   localparam int ADDR_W = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [7:0]  req_addr = 8'h00;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_w_en;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Word memory: one-cycle synchronous read, word write; preload port for setup.
   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_idx = 6'd0;
   logic [31:0] pl_dat = 32'd0;

   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_dat;
      else if (mem_w_en) mem[mem_addr[7:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:2]];
   end

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   function automatic logic [31:0] model_load(logic [31:0] w, logic [1:0] size, logic uns, logic [7:0] a);
      int unsigned v;
      if (size[1]) begin
         v = (w >> (8 * int'(a[1:0]))) & 32'hFF;
         if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (size == 2'b01) begin
         v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
         if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_merge(logic [31:0] w, logic [1:0] size, logic [7:0] a, logic [31:0] wd);
      int unsigned sh;
      if (size[1]) begin
         sh = 8 * int'(a[1:0]);
         return (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      end else if (size == 2'b01) begin
         sh = 16 * int'(a[1]);
         return (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      end
      return wd;
   endfunction

   function automatic bit model_misaligned(logic [1:0] size, logic [7:0] a);
      if (size == 2'b01) return (a % 2) != 0;
      if (size == 2'b00) return (a % 4) != 0;
      return 1'b0;
   endfunction

   function automatic int model_latency(logic we, logic [1:0] size, logic [7:0] a);
      if (model_misaligned(size, a)) return 1;
      if (!we) return 2;
      if (size == 2'b00) return 2;
      return 3;
   endfunction

   // Issues one request in cycle 0 and observes cycles 1..8 (sampled on negedge).
   task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [7:0] addr, input logic [31:0] wd,
                          output bit acc, output int resp_cyc, output logic [31:0] rd,
                          output logic er, output int wen_cnt, output int wen_cyc,
                          output logic [31:0] wen_dat, output int nresp, output int rdy_low);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      acc = req_ready;
      resp_cyc = -1; rd = 'x; er = 'x; wen_cnt = 0; wen_cyc = -1; wen_dat = 'x;
      nresp = 0; rdy_low = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (mem_w_en) begin wen_cnt++; wen_cyc = c; wen_dat = mem_wdata; end
         if (resp_valid) begin
            nresp++;
            if (resp_cyc < 0) begin resp_cyc = c; rd = resp_rdata; er = resp_err; end
         end
         if (!req_ready) rdy_low++;
         if (c == 1) begin
            // Fields need not be held after acceptance.
            req_valid = 1'b0; req_addr = 8'($urandom); req_wdata = $urandom;
            req_size = 2'($urandom); req_we = 1'($urandom); req_unsigned = 1'($urandom);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      req_addr = 8'h5C;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         pl_en = 1'b1; pl_idx = 6'(i);
         pl_dat = (i == 4) ? 32'h8899_AABB : $urandom;
         ref_mem[i] = pl_dat;
      end
      @(negedge clk);
      pl_en = 1'b0;
      @(negedge clk);
      n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", req_ready); end
      n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
      n_tests++; if (resp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
      n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", resp_err); end
      n_tests++; if (mem_w_en !== 1'b0) begin n_fail++; $display("FAIL rst_wen got %b want 0", mem_w_en); end
      n_tests++; if (mem_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
      n_tests++; if (mem_addr !== 8'h5C) begin n_fail++; $display("FAIL rst_idle_addr got %h want 5c", mem_addr); end
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got %b want 1", req_ready); end
   endtask

   typedef struct packed {
      logic [1:0]  size;
      logic        uns;
      logic [7:0]  addr;
      logic [31:0] exp;
   } ld_vec_t;

   task automatic test_loads();
      ld_vec_t v [6];
      bit acc; int rc, wc, wcy, nr, rl; logic [31:0] rd, wdat; logic er;
      v[0] = '{2'b10, 1'b0, 8'h13, 32'hFFFF_FF88};
      v[1] = '{2'b10, 1'b1, 8'h13, 32'h0000_0088};
      v[2] = '{2'b11, 1'b0, 8'h10, 32'hFFFF_FFBB};
      v[3] = '{2'b01, 1'b0, 8'h12, 32'hFFFF_8899};
      v[4] = '{2'b01, 1'b1, 8'h10, 32'h0000_AABB};
      v[5] = '{2'b00, 1'b1, 8'h10, 32'h8899_AABB};
      for (int i = 0; i < 6; i++) begin
         run_req(1'b0, v[i].size, v[i].uns, v[i].addr, $urandom, acc, rc, rd, er, wc, wcy, wdat, nr, rl);
         n_tests++; if (rc !== 2) begin n_fail++; $display("FAIL ld%0d_cycle got %0d want 2", i, rc); end
         n_tests++; if (rd !== v[i].exp) begin n_fail++; $display("FAIL ld%0d_rdata got %h want %h", i, rd, v[i].exp); end
         n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL ld%0d_err got %b want 0", i, er); end
         n_tests++; if (wc !== 0) begin n_fail++; $display("FAIL ld%0d_wen got %0d want 0", i, wc); end
         n_tests++; if (resp_rdata !== v[i].exp) begin n_fail++; $display("FAIL ld%0d_hold got %h want %h", i, resp_rdata, v[i].exp); end
      end
   endtask

   task automatic test_sub_store();
      bit acc; int rc, wc, wcy, nr, rl; logic [31:0] rd, wdat; logic er;
      run_req(1'b1, 2'b10, 1'b0, 8'h11, 32'h1234_5677, acc, rc, rd, er, wc, wcy, wdat, nr, rl);
      ref_mem[4] = model_merge(ref_mem[4], 2'b10, 8'h11, 32'h1234_5677);
      n_tests++; if (wc !== 1) begin n_fail++; $display("FAIL sb_wen_count got %0d want 1", wc); end
      n_tests++; if (wcy !== 2) begin n_fail++; $display("FAIL sb_wen_cycle got %0d want 2", wcy); end
      n_tests++; if (wdat !== 32'h8899_77BB) begin n_fail++; $display("FAIL sb_wdata got %h want 889977bb", wdat); end
      n_tests++; if (rc !== 3) begin n_fail++; $display("FAIL sb_resp_cycle got %0d want 3", rc); end
      n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL sb_rdata got %h want 0", rd); end
      n_tests++; if (rl !== 3) begin n_fail++; $display("FAIL sb_ready_low got %0d want 3", rl); end
      run_req(1'b0, 2'b00, 1'b0, 8'h10, 32'd0, acc, rc, rd, er, wc, wcy, wdat, nr, rl);
      n_tests++; if (rd !== 32'h8899_77BB) begin n_fail++; $display("FAIL sb_readback got %h want 889977bb", rd); end
   endtask

   task automatic test_misaligned();
      bit acc; int rc, wc, wcy, nr, rl; logic [31:0] rd, wdat; logic er;
      run_req(1'b1, 2'b01, 1'b0, 8'h11, $urandom, acc, rc, rd, er, wc, wcy, wdat, nr, rl);
      n_tests++; if (rc !== 1) begin n_fail++; $display("FAIL mis_resp_cycle got %0d want 1", rc); end
      n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL mis_err got %b want 1", er); end
      n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL mis_rdata got %h want 0", rd); end
      n_tests++; if (wc !== 0) begin n_fail++; $display("FAIL mis_wen got %0d want 0", wc); end
      n_tests++; if (mem[4] !== ref_mem[4]) begin n_fail++; $display("FAIL mis_word got %h want %h", mem[4], ref_mem[4]); end
      n_tests++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL mis_err_hold got %b want 1", resp_err); end
   endtask

   task automatic test_back_to_back();
      int nresp = 0, ready_bad = 0, wen = 0, ld_cyc = -1;
      logic [31:0] ld_dat = 'x;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 8'h14; req_wdata = 32'hDEAD_BEEF;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         if (req_ready) ready_bad++;
         if (resp_valid) nresp++;
         if (mem_w_en) wen++;
      end
      @(negedge clk);
      n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready3 got %b want 1", req_ready); end
      if (resp_valid) nresp++;
      req_we = 1'b0; req_addr = 8'h14;
      for (int c = 4; c <= 10; c++) begin
         @(negedge clk);
         if (c == 4) req_valid = 1'b0;
         if (mem_w_en) wen++;
         if (resp_valid) begin nresp++; if (ld_cyc < 0) begin ld_cyc = c; ld_dat = resp_rdata; end end
      end
      ref_mem[5] = 32'hDEAD_BEEF;
      n_tests++; if (ready_bad !== 0) begin n_fail++; $display("FAIL b2b_ready_low got %0d high cycles want 0", ready_bad); end
      n_tests++; if (nresp !== 2) begin n_fail++; $display("FAIL b2b_resp_count got %0d want 2", nresp); end
      n_tests++; if (wen !== 1) begin n_fail++; $display("FAIL b2b_wen_count got %0d want 1", wen); end
      n_tests++; if (ld_cyc !== 5) begin n_fail++; $display("FAIL b2b_ld_cycle got %0d want 5", ld_cyc); end
      n_tests++; if (ld_dat !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL b2b_ld_data got %h want deadbeef", ld_dat); end
   endtask

   task automatic test_reset_mid_write();
      int nresp = 0, ready_bad = 0;
      logic wen_before, wen_after;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 8'h10; req_wdata = $urandom;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      wen_before = mem_w_en;
      rst_n = 1'b0;
      #1;
      wen_after = mem_w_en;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (resp_valid) nresp++;
         if (!req_ready) ready_bad++;
      end
      n_tests++; if (wen_before !== 1'b1) begin n_fail++; $display("FAIL rmw_wr_state got %b want 1", wen_before); end
      n_tests++; if (wen_after !== 1'b0) begin n_fail++; $display("FAIL rmw_async_drop got %b want 0", wen_after); end
      n_tests++; if (nresp !== 0) begin n_fail++; $display("FAIL rmw_no_resp got %0d want 0", nresp); end
      n_tests++; if (ready_bad !== 0) begin n_fail++; $display("FAIL rmw_ready got %0d low cycles want 0", ready_bad); end
      n_tests++; if (mem[4] !== ref_mem[4]) begin n_fail++; $display("FAIL rmw_word got %h want %h", mem[4], ref_mem[4]); end
   endtask

   task automatic test_random();
      bit acc; int rc, wc, wcy, nr, rl, lat, bad; logic [31:0] rd, wdat, exp_rd, exp_w; logic er;
      logic we, uns; logic [1:0] size; logic [7:0] a; logic [31:0] wd; bit mis;
      for (int i = 0; i < 40; i++) begin
         we = 1'($urandom); uns = 1'($urandom); size = 2'($urandom);
         a = 8'($urandom); wd = $urandom;
         mis = model_misaligned(size, a);
         lat = model_latency(we, size, a);
         exp_rd = (mis || we) ? 32'd0 : model_load(ref_mem[a[7:2]], size, uns, a);
         exp_w = model_merge(ref_mem[a[7:2]], size, a, wd);
         run_req(we, size, uns, a, wd, acc, rc, rd, er, wc, wcy, wdat, nr, rl);
         n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_accept got %b want 1", i, acc); end
         n_tests++; if (rc !== lat) begin n_fail++; $display("FAIL rnd%0d_cycle got %0d want %0d", i, rc, lat); end
         n_tests++; if (er !== mis) begin n_fail++; $display("FAIL rnd%0d_err got %b want %b", i, er, mis); end
         n_tests++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd%0d_rdata got %h want %h", i, rd, exp_rd); end
         n_tests++; if (nr !== 1) begin n_fail++; $display("FAIL rnd%0d_resp_count got %0d want 1", i, nr); end
         n_tests++; if (rl !== lat) begin n_fail++; $display("FAIL rnd%0d_ready_low got %0d want %0d", i, rl, lat); end
         n_tests++; if (wc !== ((we && !mis) ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_wen_count got %0d want %0d", i, wc, (we && !mis) ? 1 : 0); end
         if (we && !mis) begin
            n_tests++; if (wdat !== exp_w) begin n_fail++; $display("FAIL rnd%0d_wdata got %h want %h", i, wdat, exp_w); end
            n_tests++; if (wcy !== lat - 1) begin n_fail++; $display("FAIL rnd%0d_wen_cycle got %0d want %0d", i, wcy, lat - 1); end
            ref_mem[a[7:2]] = exp_w;
         end
      end
      bad = 0;
      for (int k = 0; k < 64; k++) if (mem[k] !== ref_mem[k]) bad++;
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rnd_mem_image got %0d differing words want 0", bad); end
   endtask

   initial begin
      #1;
      test_reset();
      test_loads();
      test_sub_store();
      test_misaligned();
      test_back_to_back();
      test_reset_mid_write();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front-end that sits directly upstream of the word-only data memory (`Mem`: 8-bit byte address, word index `addr[7:2]`, one-cycle synchronous read, word write on `w_en`). It accepts byte, halfword and word requests from the pipeline MEM stage. Loads are served by lane extraction with sign or zero extension. Sub-word stores are served by a read-modify-write sequence. Misaligned accesses are rejected without touching memory.

## Interface
- `ADDR_W`, 8: byte address width; the memory word index is `ADDR_W-2` bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 word, 01 halfword, 1x byte.
- `req_unsigned`  in  1  loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data; uses the low byte or halfword for sub-word stores.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned access; qualified by `resp_valid`.
- `mem_w_en`  out  1  to `Mem.w_en`.
- `mem_addr`  out  ADDR_W  to `Mem.addr`.
- `mem_wdata`  out  32  to `Mem.data_in`.
- `mem_rdata`  in  32  from `Mem.data_out`; valid one cycle after its address is presented.

## Operation
- Byte order is little-endian: byte lane k = `addr[1:0]` occupies bits [8k+7:8k]. The halfword lane is selected by `addr[1]`.
- Handshake:
  - A request is accepted when `req_valid && req_ready`.
  - Request fields are latched on acceptance and need not be held afterwards.
  - `req_ready` is low from the cycle after acceptance until the unit returns to IDLE.
- Misaligned access: halfword with `addr[0]=1`, or word with `addr[1:0]!=0`. Goes IDLE -> RESP with `resp_err=1`. `mem_w_en` is never asserted.
- FSM states: IDLE, LD, MERGE, WR, RESP.
  - IDLE: `mem_addr = req_addr` combinationally, `mem_w_en = 0`. A read is always in flight, which is harmless.
    - On acceptance: aligned load -> LD; sub-word store -> MERGE; word store -> WR; misaligned -> RESP.
  - LD: `mem_rdata` valid. Extract the lane, extend it, register it into `resp_rdata`. Next state RESP.
  - MERGE: `mem_rdata` valid. Replace the addressed byte or halfword lane with the `req_wdata` low bits, register the result into the write-data register. Next state WR.
  - WR: `mem_w_en = 1`, `mem_addr` = latched address, `mem_wdata` = write-data register. For a word store, the write-data register was loaded with `req_wdata` at acceptance. Next state RESP.
  - RESP: `resp_valid = 1` for exactly one cycle. Next state IDLE.
- Extension: a byte sign-extends from bit 7 and a halfword from bit 15 unless `req_unsigned`. Word loads ignore `req_unsigned`.
- `mem_w_en` is decoded from the state register only, so it is glitch-free.

## Timing
- Acceptance is cycle 0.
  - Load: `resp_valid` in cycle 2.
  - Word store: write in cycle 1, `resp_valid` in cycle 2.
  - Sub-word store: read issued in cycle 0, merge in cycle 1, write in cycle 2, `resp_valid` in cycle 3.
  - Misaligned: `resp_valid` with `resp_err` in cycle 1.
- Next acceptance at the earliest one cycle after RESP; there are no back-to-back accepts.
- Reset values:
  - State: IDLE, so `req_ready=1`.
  - `resp_valid=0`, `resp_rdata=0`, `resp_err=0`.
  - `mem_w_en=0`; `mem_wdata` register 0; latched address 0.
- Reset mid-operation aborts with no response.
  - Reset asserted while in WR drops `mem_w_en` immediately.
  - The memory is unchanged if reset is asserted before the WR-cycle clock edge.
- `resp_rdata` and `resp_err` hold their values until the next RESP.

## Structure
- Package `mem_pkg` holds:
  - size encodings `SIZE_WORD=2'b00`, `SIZE_HALF=2'b01`, `SIZE_BYTE=2'b1?`;
  - FSM state encoding;
  - a misalignment-check function.
- Sub-module `sub_word_lane`, purely combinational:
  - lane extract plus extension, used for loads;
  - lane merge, used for stores;
  - inputs: size, `addr[1:0]`, unsigned flag, word in, store data.
- The top level holds the FSM and request/response registers and instantiates `Mem` in the testbench only.

## Test plan
- Word 0x10 preloaded with 0x8899AABB:
  - LB 0x13 -> `resp_rdata=0xFFFFFF88` in cycle 2.
  - LBU 0x13 -> 0x00000088.
  - LB 0x10 -> 0xFFFFFFBB.
- Same word:
  - LH 0x12 -> 0xFFFF8899.
  - LHU 0x10 -> 0x0000AABB.
  - LW 0x10 -> 0x8899AABB with `resp_err=0`.
- SB 0x11, `req_wdata=0x12345677`:
  - `mem_w_en` high only in cycle 2, with `mem_wdata=0x889977BB`.
  - A following LW 0x10 returns 0x889977BB.
- SH 0x11 (misaligned):
  - `resp_valid` and `resp_err` in cycle 1, `resp_rdata=0`.
  - `mem_w_en` never high; the word is unchanged.
- SW 0x14 0xDEADBEEF with `req_valid` held high, then LW 0x14:
  - `req_ready` low in cycles 1–2.
  - Load returns 0xDEADBEEF.
  - Exactly one `resp_valid` per request.
- SB 0x10 with `rst_n` pulsed low during WR, before the edge:
  - `mem_w_en` drops asynchronously; no `resp_valid`.
  - `req_ready=1` after release; word 0x10 unchanged.
